dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single-port data memory between the CPU datapath and an external host/debug port (loader, scoreboard, monitor).
- One memory access per cycle.
- CPU has priority; a starvation counter forces a host slot and stalls the CPU that cycle through cpu_stall, which the program sequencer honours.
- Sits between the computational unit / instruction decoder and data_memory; it drives the memory address, write data and write enable.

Parameters:
- ADDR_W, 4, data memory address width
- DATA_W, 4, data word width
- STARVE_LIMIT, 8, consecutive denied host cycles before a forced host slot (legal range 1..255)

Ports:
- clk  in  1  system clock; all state on rising edge
- sync_reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access this cycle (read or write)
- cpu_w_en  in  1  CPU write strobe, qualified by cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle (combinational)
- cpu_stall  out  1  CPU access denied; sequencer must hold PC and decoder must suppress register enables
- cpu_rdata  out  DATA_W  read data for the CPU access granted in the previous cycle
- host_req  in  1  host request; held until host_gnt
- host_we  in  1  host write
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host request accepted this cycle (combinational)
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid; one-cycle pulse
- mem_addr  out  ADDR_W  to data memory
- mem_data_in  out  DATA_W  to data memory
- mem_w_en  out  1  to data memory
- mem_data_out  in  DATA_W  from data memory; valid the cycle after the address is presented

Behaviour:
- Reset: sync_reset is sampled on the rising edge of clk (synchronous, active-high). The following outputs and state are forced to 0 at that edge and held while it is asserted:
  - cpu_gnt, cpu_stall, host_gnt, host_rvalid
  - cpu_rdata, host_rdata
  - mem_w_en, mem_addr, mem_data_in
  - starvation counter
- FSM state after reset: IDLE.
- FSM states:
  - IDLE: no host request pending.
  - PEND: host_req is high and was denied.
  - FORCE: counter has reached STARVE_LIMIT.
- Arbitration, combinational within the cycle:
  - Host granted when host_req and (not cpu_req or state==FORCE).
  - Otherwise the CPU is granted when cpu_req.
  - cpu_stall = cpu_req and host_gnt. This is only possible in FORCE.
- Memory mux:
  - mem_* take the winner's address and data.
  - mem_w_en = winner's write strobe.
  - No winner: mem_w_en = 0 and mem_addr holds its previous value.
- Read return:
  - A granted read in cycle N returns mem_data_out in cycle N+1 on cpu_rdata, or on host_rdata with host_rvalid = 1.
  - A one-bit "owner" register records which requester owns the returning data.
  - Granted writes produce no rvalid.
  - cpu_rdata / host_rdata hold their last value otherwise.
- Starvation counter (8-bit):
  - Increments each cycle host_req=1 and host_gnt=0.
  - Saturates at STARVE_LIMIT.
  - Clears on host_gnt, or when host_req=0.
- FSM transitions, registered:
  - IDLE -> PEND on a denied host_req.
  - PEND -> FORCE when the counter's next value equals STARVE_LIMIT.
  - Any state -> IDLE on host_gnt or host_req=0.
- STARVE_LIMIT=1: FORCE is reached after one denied cycle, so the host wins on the second cycle.
- Host withdraw: host_req dropped before grant is tolerated; no access occurs and the counter clears.
- Back-to-back host requests: the counter restarts from 0 after every grant, so a continuously busy CPU yields at most 1 slot per STARVE_LIMIT+1 cycles.
- Reset mid-operation: a pending read return is discarded; host_rvalid stays 0 on the cycle after reset.
- Same address in consecutive cycles from different owners: no forwarding is needed because accesses are strictly serialised.

Decomposition:
- Package dm_arb_pkg holds:
  - state enum {IDLE, PEND, FORCE}
  - owner enum {OWN_CPU, OWN_HOST}
  - default ADDR_W and DATA_W constants
- Sub-module starve_counter:
  - Ports: clk, sync_reset, inc, clr, limit, at_limit.
  - Saturating counter; instantiated once.

Test Plan:
- Reset: assert sync_reset for 2 cycles during an active host read -> every output 0, host_rvalid never pulses after release.
- Idle host: cpu_req=0; host write addr 3 data 0xA, then host read addr 3 -> host_gnt in each request cycle, host_rvalid=1 with host_rdata=0xA one cycle after the read grant.
- CPU priority: cpu_req=1 every cycle, host_req=1, STARVE_LIMIT=8 -> host_gnt=0 for 8 cycles, host_gnt=1 and cpu_stall=1 on cycle 9, cpu_gnt=0 that cycle.
- Simultaneous burst: CPU writes addr 5=0x7 while host waits, then forced host read addr 5 -> host_rdata=0x7; the next CPU read of addr 5 returns cpu_rdata=0x7 and no stall.
- Withdraw: host_req high 4 cycles under CPU load, then low -> no mem_w_en from host, counter back to 0, state IDLE; re-request waits a full 8 cycles again.
- STARVE_LIMIT=1 build: constant CPU load plus continuous host requests -> host and CPU alternate grants, cpu_stall asserted every second cycle.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dm_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {IDLE, PEND, FORCE} arb_state_e;
    typedef enum logic {OWN_CPU, OWN_HOST} owner_e;

endpackage

// File: rtl/dm_arbiter_starve_counter.sv
// Saturating count of consecutive denied host cycles; at_limit looks at the
// value the counter is about to take so the FSM can enter FORCE in time.
module starve_counter
    import dm_arb_pkg::*;
(
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q < limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    assign at_limit = (count_d == limit);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data memory arbiter: CPU has priority, the host gets a forced
// slot (stalling the CPU) after STARVE_LIMIT consecutive denied cycles.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              cpu_req,
    input  logic              cpu_w_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_w_en,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              cnt_inc, cnt_clr, at_limit;

    // Everything visible is forced low while reset is held, not just after it.
    always_comb begin
        host_gnt    = 1'b0;
        cpu_gnt     = 1'b0;
        cpu_stall   = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        mem_w_en    = 1'b0;
        host_rvalid = 1'b0;
        cpu_rdata   = '0;
        host_rdata  = '0;
        if (!sync_reset) begin
            host_gnt    = host_req && (!cpu_req || (state_q == FORCE));
            cpu_gnt     = cpu_req && !host_gnt;
            cpu_stall   = cpu_req && host_gnt;
            mem_addr    = mem_addr_q;
            if (host_gnt) begin
                mem_addr    = host_addr;
                mem_data_in = host_wdata;
                mem_w_en    = host_we;
            end else if (cpu_gnt) begin
                mem_addr    = cpu_addr;
                mem_data_in = cpu_wdata;
                mem_w_en    = cpu_w_en;
            end
            host_rvalid = rd_pend_q && (owner_q == OWN_HOST);
            cpu_rdata   = (rd_pend_q && (owner_q == OWN_CPU)) ? mem_data_out : cpu_rdata_q;
            host_rdata  = host_rvalid ? mem_data_out : host_rdata_q;
        end
    end

    assign cnt_inc = host_req && !host_gnt;
    assign cnt_clr = host_gnt || !host_req;

    starve_counter u_starve (
        .clk        (clk),
        .sync_reset (sync_reset),
        .inc        (cnt_inc),
        .clr        (cnt_clr),
        .limit      (LIMIT),
        .at_limit   (at_limit)
    );

    // With a limit of 1 the first denial already reaches the limit, so IDLE may jump straight to FORCE.
    always_comb begin
        state_d      = IDLE;
        owner_d      = host_gnt ? OWN_HOST : OWN_CPU;
        rd_pend_d    = (host_gnt && !host_we) || (cpu_gnt && !cpu_w_en);
        cpu_rdata_d  = cpu_rdata;
        host_rdata_d = host_rdata;
        mem_addr_d   = mem_addr;
        case (state_q)
            IDLE, PEND: if (cnt_inc) state_d = at_limit ? FORCE : PEND;
            FORCE:      state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            rd_pend_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rd_pend_q    <= rd_pend_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: two instances (limit 8 and limit 1) share stimulus and
// are compared every cycle against a behavioural model of the arbitration rules.
module tb_dm_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_w_en, host_req, host_we;
    logic [3:0] cpu_addr, cpu_wdata, host_addr, host_wdata;

    logic       cpu_gnt_o [2];
    logic       cpu_stall_o [2];
    logic       host_gnt_o [2];
    logic       host_rvalid_o [2];
    logic       mem_w_en_o [2];
    logic [3:0] cpu_rdata_o [2];
    logic [3:0] host_rdata_o [2];
    logic [3:0] mem_addr_o [2];
    logic [3:0] mem_data_in_o [2];
    logic [3:0] mem_data_out_i [2];
    logic [3:0] mem [2][16];

    int total = 0;
    int bad = 0;

    int         limits [2] = '{8, 1};
    int         m_denied [2];
    int         m_pend [2];
    logic [3:0] m_last [2];
    logic [3:0] m_cpu_rd [2];
    logic [3:0] m_host_rd [2];
    logic [3:0] m_ret [2];
    logic [3:0] m_shadow [2][16];

    logic       snap_cg [2];
    logic       snap_st [2];
    logic       snap_hg [2];
    logic       snap_rv [2];
    logic       snap_we [2];
    logic [3:0] snap_hrd [2];
    logic [3:0] snap_crd [2];

    typedef struct {
        logic       cr, cw;
        logic [3:0] ca, cd;
        logic       hr, hw;
        logic [3:0] ha, hd;
        logic       e_cg, e_st, e_hg, e_rv;
        logic [3:0] e_hrd, e_crd;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(4), .DATA_W(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .sync_reset(rst),
        .cpu_req(cpu_req), .cpu_w_en(cpu_w_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt_o[0]), .cpu_stall(cpu_stall_o[0]), .cpu_rdata(cpu_rdata_o[0]),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt_o[0]), .host_rdata(host_rdata_o[0]), .host_rvalid(host_rvalid_o[0]),
        .mem_addr(mem_addr_o[0]), .mem_data_in(mem_data_in_o[0]), .mem_w_en(mem_w_en_o[0]),
        .mem_data_out(mem_data_out_i[0])
    );

    dm_arbiter #(.ADDR_W(4), .DATA_W(4), .STARVE_LIMIT(1)) dut_l1 (
        .clk(clk), .sync_reset(rst),
        .cpu_req(cpu_req), .cpu_w_en(cpu_w_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt_o[1]), .cpu_stall(cpu_stall_o[1]), .cpu_rdata(cpu_rdata_o[1]),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt_o[1]), .host_rdata(host_rdata_o[1]), .host_rvalid(host_rvalid_o[1]),
        .mem_addr(mem_addr_o[1]), .mem_data_in(mem_data_in_o[1]), .mem_w_en(mem_w_en_o[1]),
        .mem_data_out(mem_data_out_i[1])
    );

    // Synchronous-read memories, one per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_w_en_o[i]) mem[i][mem_addr_o[i]] <= mem_data_in_o[i];
            mem_data_out_i[i] <= mem[i][mem_addr_o[i]];
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setInputs(input logic cr, input logic cw, input logic [3:0] ca, input logic [3:0] cd,
                             input logic hr, input logic hw, input logic [3:0] ha, input logic [3:0] hd);
        cpu_req = cr; cpu_w_en = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    // One cycle: compare both instances against the model at the falling edge,
    // advance the model, then step past the rising edge.
    task automatic applyStimulus();
        logic       hg, cg, st, rv, we, granted;
        logic [3:0] ma, md, hrd, crd, a, d;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            hg = 0; cg = 0; st = 0; rv = 0; we = 0; ma = 0; md = 0; hrd = 0; crd = 0;
            if (!rst) begin
                hg  = host_req && (!cpu_req || m_denied[i] >= limits[i]);
                cg  = cpu_req && !hg;
                st  = cpu_req && hg;
                ma  = hg ? host_addr : (cg ? cpu_addr : m_last[i]);
                md  = hg ? host_wdata : (cg ? cpu_wdata : 4'h0);
                we  = hg ? host_we : (cg ? cpu_w_en : 1'b0);
                rv  = (m_pend[i] == 2);
                hrd = rv ? m_ret[i] : m_host_rd[i];
                crd = (m_pend[i] == 1) ? m_ret[i] : m_cpu_rd[i];
            end
            checkOutput($sformatf("d%0d_cpu_gnt", i), cpu_gnt_o[i], cg);
            checkOutput($sformatf("d%0d_cpu_stall", i), cpu_stall_o[i], st);
            checkOutput($sformatf("d%0d_host_gnt", i), host_gnt_o[i], hg);
            checkOutput($sformatf("d%0d_host_rvalid", i), host_rvalid_o[i], rv);
            checkOutput($sformatf("d%0d_host_rdata", i), host_rdata_o[i], hrd);
            checkOutput($sformatf("d%0d_cpu_rdata", i), cpu_rdata_o[i], crd);
            checkOutput($sformatf("d%0d_mem_addr", i), mem_addr_o[i], ma);
            checkOutput($sformatf("d%0d_mem_data_in", i), mem_data_in_o[i], md);
            checkOutput($sformatf("d%0d_mem_w_en", i), mem_w_en_o[i], we);
            snap_cg[i] = cpu_gnt_o[i]; snap_st[i] = cpu_stall_o[i]; snap_hg[i] = host_gnt_o[i];
            snap_rv[i] = host_rvalid_o[i]; snap_we[i] = mem_w_en_o[i];
            snap_hrd[i] = host_rdata_o[i]; snap_crd[i] = cpu_rdata_o[i];
            if (rst) begin
                m_denied[i] = 0; m_pend[i] = 0; m_last[i] = 0;
                m_cpu_rd[i] = 0; m_host_rd[i] = 0; m_ret[i] = 0;
            end else begin
                m_cpu_rd[i]  = crd;
                m_host_rd[i] = hrd;
                granted = hg || cg;
                a = hg ? host_addr : cpu_addr;
                d = hg ? host_wdata : cpu_wdata;
                m_pend[i] = 0;
                if (granted) begin
                    m_last[i] = a;
                    if (we) m_shadow[i][a] = d;
                    else begin
                        m_ret[i]  = m_shadow[i][a];
                        m_pend[i] = hg ? 2 : 1;
                    end
                end
                m_denied[i] = (host_req && !hg) ? m_denied[i] + 1 : 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic cr, cw, input logic [3:0] ca, cd,
                                 input logic hr, hw, input logic [3:0] ha, hd,
                                 input logic e_cg, e_st, e_hg, e_rv, input logic [3:0] e_hrd, e_crd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
        v.e_cg = e_cg; v.e_st = e_st; v.e_hg = e_hg; v.e_rv = e_rv; v.e_hrd = e_hrd; v.e_crd = e_crd;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_denied[i] = 0; m_pend[i] = 0; m_last[i] = 0;
            m_cpu_rd[i] = 0; m_host_rd[i] = 0; m_ret[i] = 0;
            for (int j = 0; j < 16; j++) m_shadow[i][j] = 0;
        end
        rst = 1'b1;
        setInputs(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus();
        applyStimulus();
        rst = 1'b0;

        // Preload both memories with zeros through the idle host path.
        for (int j = 0; j < 16; j++) begin
            setInputs(0, 0, 0, 0, 1, 1, 4'(j), 4'h0);
            applyStimulus();
            checkOutput("preload_host_gnt", snap_hg[0], 1);
        end

        // Reset in the middle of a host read: the returning data must be dropped.
        setInputs(0, 0, 0, 0, 1, 0, 4'h3, 4'h0);
        applyStimulus();
        checkOutput("rst_pre_host_gnt", snap_hg[0], 1);
        rst = 1'b1;
        applyStimulus();
        checkOutput("rst_host_gnt", snap_hg[0], 0);
        applyStimulus();
        rst = 1'b0;
        setInputs(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus();
        checkOutput("rst_after_rvalid", snap_rv[0], 0);
        checkOutput("rst_after_host_rdata", snap_hrd[0], 0);

        // Idle host write/read, CPU priority with forced slot, then read-back by CPU.
        tbl.push_back(mkv(0, 0, 0, 0, 1, 1, 4'h3, 4'hA, 0, 0, 1, 0, 4'h0, 4'h0));
        tbl.push_back(mkv(0, 0, 0, 0, 1, 0, 4'h3, 4'h0, 0, 0, 1, 0, 4'h0, 4'h0));
        tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 1, 4'hA, 4'h0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mkv(1, 1, 4'h5, 4'h7, 1, 0, 4'h5, 4'h0, 1, 0, 0, 0, 4'hA, 4'h0));
        tbl.push_back(mkv(1, 1, 4'h5, 4'h7, 1, 0, 4'h5, 4'h0, 0, 1, 1, 0, 4'hA, 4'h0));
        tbl.push_back(mkv(1, 0, 4'h5, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 1, 4'h7, 4'h0));
        tbl.push_back(mkv(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h7, 4'h7));
        foreach (tbl[k]) begin
            setInputs(tbl[k].cr, tbl[k].cw, tbl[k].ca, tbl[k].cd, tbl[k].hr, tbl[k].hw, tbl[k].ha, tbl[k].hd);
            applyStimulus();
            checkOutput($sformatf("tbl%0d_cpu_gnt", k), snap_cg[0], tbl[k].e_cg);
            checkOutput($sformatf("tbl%0d_cpu_stall", k), snap_st[0], tbl[k].e_st);
            checkOutput($sformatf("tbl%0d_host_gnt", k), snap_hg[0], tbl[k].e_hg);
            checkOutput($sformatf("tbl%0d_host_rvalid", k), snap_rv[0], tbl[k].e_rv);
            checkOutput($sformatf("tbl%0d_host_rdata", k), snap_hrd[0], tbl[k].e_hrd);
            checkOutput($sformatf("tbl%0d_cpu_rdata", k), snap_crd[0], tbl[k].e_crd);
        end

        // Host withdraws after 4 denied cycles; a new request must wait the full limit again.
        for (int k = 0; k < 4; k++) begin
            setInputs(1, 0, 4'h1, 4'h0, 1, 1, 4'h9, 4'hF);
            applyStimulus();
            checkOutput("wd_host_gnt", snap_hg[0], 0);
            checkOutput("wd_mem_w_en", snap_we[0], 0);
        end
        setInputs(1, 0, 4'h1, 4'h0, 0, 0, 4'h0, 4'h0);
        applyStimulus();
        checkOutput("wd_drop_host_gnt", snap_hg[0], 0);
        checkOutput("wd_drop_mem_w_en", snap_we[0], 0);
        for (int k = 0; k < 9; k++) begin
            setInputs(1, 0, 4'h1, 4'h0, 1, 1, 4'h9, 4'hF);
            applyStimulus();
            checkOutput($sformatf("wd_rereq%0d_host_gnt", k), snap_hg[0], (k == 8) ? 1 : 0);
            checkOutput($sformatf("wd_rereq%0d_cpu_stall", k), snap_st[0], (k == 8) ? 1 : 0);
        end

        // Limit-1 instance alternates host and CPU under continuous load.
        setInputs(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus();
        for (int k = 0; k < 6; k++) begin
            setInputs(1, 0, 4'h4, 4'h0, 1, 0, 4'h2, 4'h0);
            applyStimulus();
            checkOutput($sformatf("l1_c%0d_host_gnt", k), snap_hg[1], k % 2);
            checkOutput($sformatf("l1_c%0d_cpu_stall", k), snap_st[1], k % 2);
            checkOutput($sformatf("l1_c%0d_cpu_gnt", k), snap_cg[1], 1 - (k % 2));
        end

        // Randomised traffic with occasional resets, checked by the model only.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            setInputs($urandom_range(0, 2) != 0, 1'($urandom), 4'($urandom), 4'($urandom),
                      $urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 4'($urandom));
            applyStimulus();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
